ora_seq_checker: RTL

ORA_SEQ_CHECKER -- requirements
Module: ora_seq_checker

---
 rtl/ora_seq_checker.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ora_seq_checker.sv
// NoC sink that checks per-source data sequencing, destination and stream id
// of every accepted flit, keeping counters and a first-error capture.
module ora_seq_checker #(
  parameter int         i0_WIDTH      = 32,
  parameter int         N             = 16,
  parameter int         N_ADDR_WIDTH  = $clog2(N),
  parameter int         NODE          = 15,
  parameter logic [7:0] EXP_ID        = 8'd0,
  parameter int         STALL_EVERY   = 0,
  parameter int         EXPECTED_PKTS = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [i0_WIDTH-1:0]     i0_data_in,
  input  logic                    i0_valid_in,
  output logic                    i0_ready_out,
  output logic [31:0]             pkt_count,
  output logic [15:0]             err_count,
  output logic                    err_flag,
  output logic [N_ADDR_WIDTH-1:0] first_err_src,
  output logic [2:0]              first_err_code,
  output logic                    done
);

  localparam int DATA_W = i0_WIDTH - 2*N_ADDR_WIDTH - 8;
  localparam logic [N_ADDR_WIDTH-1:0] NODE_A   = N_ADDR_WIDTH'(NODE);
  localparam logic [31:0]             STALL_N  = 32'(STALL_EVERY);
  localparam logic [31:0]             EXP_N    = 32'(EXPECTED_PKTS);
  localparam logic [DATA_W-1:0]       SEQ_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_INIT, S_RUN, S_STALL, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic [31:0]             pkt_count_q, pkt_count_d;
  logic [15:0]             err_count_q, err_count_d;
  logic                    err_flag_q, err_flag_d;
  logic [N_ADDR_WIDTH-1:0] first_err_src_q, first_err_src_d;
  logic [2:0]              first_err_code_q, first_err_code_d;
  logic [31:0]             stall_cnt_q, stall_cnt_d;
  logic [DATA_W-1:0]       exp_seq_q [N];

  logic [N_ADDR_WIDTH-1:0] src_s, dst_s;
  logic [7:0]              id_s;
  logic [DATA_W-1:0]       data_s, exp_s, exp_wdata_s;
  logic                    accept_s, src_ok_s, exp_wr_s;
  logic [2:0]              code_s;
  logic [31:0]             pkt_inc_s, stall_inc_s;

  // Field extraction, error code and next-state computation.
  always_comb begin
    src_s       = i0_data_in[i0_WIDTH-1 -: N_ADDR_WIDTH];
    dst_s       = i0_data_in[i0_WIDTH-1-N_ADDR_WIDTH -: N_ADDR_WIDTH];
    id_s        = i0_data_in[DATA_W +: 8];
    data_s      = i0_data_in[DATA_W-1:0];
    accept_s    = i0_valid_in && (state_q == S_RUN);
    src_ok_s    = (int'(src_s) < N);
    exp_s       = src_ok_s ? exp_seq_q[src_s] : SEQ_ONE;
    code_s      = {(data_s != exp_s), (id_s != EXP_ID), (dst_s != NODE_A)};
    exp_wr_s    = accept_s && src_ok_s;
    exp_wdata_s = data_s + SEQ_ONE;
    pkt_inc_s   = (pkt_count_q == 32'hFFFF_FFFF) ? pkt_count_q : pkt_count_q + 32'd1;
    stall_inc_s = stall_cnt_q + 32'd1;

    state_d          = state_q;
    stall_cnt_d      = stall_cnt_q;
    pkt_count_d      = pkt_count_q;
    err_count_d      = err_count_q;
    err_flag_d       = err_flag_q;
    first_err_src_d  = first_err_src_q;
    first_err_code_d = first_err_code_q;

    if (accept_s) begin
      pkt_count_d = pkt_inc_s;
      if (code_s != 3'b000) begin
        err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
        if (!err_flag_q) begin
          err_flag_d       = 1'b1;
          first_err_src_d  = src_s;
          first_err_code_d = code_s;
        end else begin
          err_flag_d = err_flag_q;
        end
      end else begin
        err_count_d = err_count_q;
      end
    end else begin
      pkt_count_d = pkt_count_q;
    end

    case (state_q)
      S_INIT:  state_d = S_RUN;
      S_RUN: begin
        if (!accept_s) begin
          state_d = S_RUN;
        end else if ((EXP_N != 32'd0) && (pkt_inc_s == EXP_N)) begin
          // Reaching the packet total wins over a coincident stall.
          state_d     = S_DONE;
          stall_cnt_d = stall_inc_s;
        end else if ((STALL_N != 32'd0) && (stall_inc_s == STALL_N)) begin
          state_d     = S_STALL;
          stall_cnt_d = 32'd0;
        end else begin
          state_d     = S_RUN;
          stall_cnt_d = stall_inc_s;
        end
      end
      S_STALL: state_d = S_RUN;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_INIT;
    endcase

    ready_d = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

  // State, counters, first-error capture and per-source sequence table.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_INIT;
      ready_q          <= 1'b0;
      done_q           <= 1'b0;
      pkt_count_q      <= 32'd0;
      err_count_q      <= 16'd0;
      err_flag_q       <= 1'b0;
      first_err_src_q  <= '0;
      first_err_code_q <= 3'b000;
      stall_cnt_q      <= 32'd0;
      for (int i = 0; i < N; i++) begin
        exp_seq_q[i] <= SEQ_ONE;
      end
    end else begin
      state_q          <= state_d;
      ready_q          <= ready_d;
      done_q           <= done_d;
      pkt_count_q      <= pkt_count_d;
      err_count_q      <= err_count_d;
      err_flag_q       <= err_flag_d;
      first_err_src_q  <= first_err_src_d;
      first_err_code_q <= first_err_code_d;
      stall_cnt_q      <= stall_cnt_d;
      if (exp_wr_s) begin
        exp_seq_q[src_s] <= exp_wdata_s;
      end
    end
  end

  assign i0_ready_out   = ready_q;
  assign pkt_count      = pkt_count_q;
  assign err_count      = err_count_q;
  assign err_flag       = err_flag_q;
  assign first_err_src  = first_err_src_q;
  assign first_err_code = first_err_code_q;
  assign done           = done_q;

endmodule
